// File: rtl/count_arb_if.sv
// count_arb_if: request/grant bundle between requesters and count_arb.
// Signals:
//   req, mode              requester -> arbiter (4 bits each, bit i = requester i)
//   gnt, busy, count       arbiter -> requester: grant, run in progress, sequence value
//   done, done_id          arbiter -> requester: run-complete pulse and its requester index
//   done_cnt               arbiter -> requester: completed-run count (COUNT_ARB_STAT_EN only)
// Modports: master (requester side), slave (arbiter side).
interface count_arb_if;
    logic [3:0] req;
    logic [3:0] mode;
    logic [3:0] gnt;
    logic       busy;
    logic [1:0] count;
    logic       done;
    logic [1:0] done_id;
`ifdef COUNT_ARB_STAT_EN
    logic [7:0] done_cnt;

    modport master (
        output req, mode,
        input  gnt, busy, count, done, done_id, done_cnt
    );
    modport slave (
        input  req, mode,
        output gnt, busy, count, done, done_id, done_cnt
    );
`else
    modport master (
        output req, mode,
        input  gnt, busy, count, done, done_id
    );
    modport slave (
        input  req, mode,
        output gnt, busy, count, done, done_id
    );
`endif
endinterface

// File: rtl/count_arb.sv
// count_arb: 4-way round-robin arbiter. The granted requester owns a shared
// 2-bit sequencer for one run: 00,01,10,11 (mode=0) or 00,10,11 (mode=1).
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-high
//   bus    count_arb_if.slave (req/mode in; gnt/busy/count/done/done_id out)
// Optional feature: define COUNT_ARB_STAT_EN to add the 8-bit done_cnt output.
module count_arb (
    input  logic        clk,
    input  logic        reset,
    count_arb_if.slave  bus
);

    typedef enum logic {IDLE, RUN} state_e;

    state_e     state_q;
    logic [1:0] ptr_q;
    logic [1:0] id_q;
    logic       m_q;
    logic [3:0] gnt_q;
    logic [1:0] count_q;
    logic       done_q;
    logic [1:0] done_id_q;
`ifdef COUNT_ARB_STAT_EN
    logic [7:0] done_cnt_q;
`endif

    logic [1:0] pick_d;
    logic [1:0] idx;
    logic [1:0] count_d;

    // Search upward from ptr with wrap; iterating from the farthest slot
    // down lets the nearest asserted requester win.
    always_comb begin
        pick_d = ptr_q;
        idx    = '0;
        for (int k = 3; k >= 0; k--) begin
            idx = ptr_q + 2'(k);
            if (bus.req[idx]) begin
                pick_d = idx;
            end
        end
    end

    // mode=1 skips 01 by jumping straight from 00 to 10.
    always_comb begin
        if (m_q && (count_q == 2'b00)) begin
            count_d = 2'b10;
        end else begin
            count_d = count_q + 2'b01;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            id_q       <= '0;
            m_q        <= 1'b0;
            gnt_q      <= '0;
            count_q    <= '0;
            done_q     <= 1'b0;
            done_id_q  <= '0;
`ifdef COUNT_ARB_STAT_EN
            done_cnt_q <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (|bus.req) begin
                        state_q <= RUN;
                        gnt_q   <= 4'b0001 << pick_d;
                        id_q    <= pick_d;
                        m_q     <= bus.mode[pick_d];
                        ptr_q   <= pick_d + 2'd1;
                        count_q <= 2'b00;
                    end
                end
                RUN: begin
                    if (count_q == 2'b11) begin
                        state_q   <= IDLE;
                        gnt_q     <= '0;
                        count_q   <= 2'b00;
                        done_q    <= 1'b1;
                        done_id_q <= id_q;
`ifdef COUNT_ARB_STAT_EN
                        done_cnt_q <= done_cnt_q + 8'd1;
`endif
                    end else begin
                        count_q <= count_d;
                    end
                end
            endcase
        end
    end

    assign bus.gnt     = gnt_q;
    assign bus.busy    = (state_q == RUN);
    assign bus.count   = count_q;
    assign bus.done    = done_q;
    assign bus.done_id = done_id_q;
`ifdef COUNT_ARB_STAT_EN
    assign bus.done_cnt = done_cnt_q;
`endif

endmodule
